// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_DEFAULT   = 16;
    localparam int BYTES_PER_WORD = WORD_DEFAULT / 8;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
interface inst_mem_loader_if #(
    parameter int WORD = 16,
    parameter int PCL  = 10
);
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            mem_we;
    logic [PCL-1:0]  mem_addr;
    logic [WORD-1:0] mem_wdata;

    // Link side: offers bytes and observes the memory writes.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes bytes and drives the memory write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// Collects BPW stream bytes (MSB first) into one word; word/word_ready are valid on the last accept.
module word_assembler
    import loader_pkg::*;
#(
    parameter int WORD = WORD_DEFAULT,
    parameter int BPW  = BYTES_PER_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            accept,
    input  logic [7:0]      in_data,
    output logic            word_ready,
    output logic [WORD-1:0] word
);

    generate
        if (WORD > 8) begin : g_multi
            localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;
            localparam logic [CW-1:0] LAST = CW'(BPW - 1);

            logic [WORD-9:0] shreg_r;
            logic [CW-1:0]   cnt_r;

            // The word is the stored upper bytes followed by the byte currently being accepted.
            assign word       = {shreg_r, in_data};
            assign word_ready = accept && (cnt_r == LAST);

            // Shift register and byte counter, cleared on a new load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shreg_r <= '0;
                    cnt_r   <= '0;
                end else if (clr) begin
                    shreg_r <= '0;
                    cnt_r   <= '0;
                end else if (accept) begin
                    shreg_r <= word[WORD-9:0];
                    cnt_r   <= word_ready ? '0 : cnt_r + CW'(1);
                end else begin
                    shreg_r <= shreg_r;
                    cnt_r   <= cnt_r;
                end
            end
        end else begin : g_single
            assign word       = in_data;
            assign word_ready = accept;
        end
    endgenerate

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte stream into instruction memory from address 0, holding the CPU while busy.
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int WORD   = WORD_DEFAULT,
    parameter int LENGTH = 1024,
    parameter int PCL    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PCL:0]    len,
    inst_mem_loader_if.slave bus,
    output logic            busy,
    output logic            done,
    output logic            cpu_hold,
    output logic [PCL:0]    words_written
);

    localparam int BPW = WORD / 8;
    localparam logic [PCL:0] LEN_MAX = (PCL+1)'(LENGTH);

    state_t          state_r, state_next_s;
    logic [PCL:0]    target_r, words_written_r, len_clamped_s;
    logic [PCL-1:0]  addr_r;
    logic [WORD-1:0] wdata_r, word_s;
    logic            in_ready_r, mem_we_r, busy_r, done_r;
    logic            in_ready_s, mem_we_s, busy_s, done_s;
    logic            start_ok_s, accept_s, word_ready_s;

    assign start_ok_s    = (state_r == IDLE) && start;
    assign accept_s      = bus.in_valid && in_ready_r;
    assign len_clamped_s = (len > LEN_MAX) ? LEN_MAX : len;

    word_assembler #(.WORD(WORD), .BPW(BPW)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok_s),
        .accept     (accept_s),
        .in_data    (bus.in_data),
        .word_ready (word_ready_s),
        .word       (word_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (len_clamped_s == '0) ? DONE : RECV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RECV: begin
                if (word_ready_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RECV;
                end
            end
            WRITE: begin
                if ((words_written_r + (PCL+1)'(1)) == target_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RECV;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        in_ready_s = 1'b0;
        mem_we_s   = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_next_s)
            IDLE: begin
                busy_s = 1'b0;
            end
            RECV: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            WRITE: begin
                mem_we_s = 1'b1;
                busy_s   = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            mem_we_r   <= mem_we_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Target latch, address/word counters and write-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r        <= '0;
            words_written_r <= '0;
            addr_r          <= '0;
            wdata_r         <= '0;
        end else begin
            if (start_ok_s) begin
                target_r        <= len_clamped_s;
                words_written_r <= '0;
                addr_r          <= '0;
            end else if (state_r == WRITE) begin
                words_written_r <= words_written_r + (PCL+1)'(1);
                addr_r          <= addr_r + PCL'(1);
            end else begin
                words_written_r <= words_written_r;
                addr_r          <= addr_r;
            end
            if (word_ready_s) begin
                wdata_r <= word_s;
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = wdata_r;
    assign busy           = busy_r;
    assign cpu_hold       = busy_r;
    assign done           = done_r;
    assign words_written  = words_written_r;

endmodule
